// File: rtl/uart_rx_deserializer_if.sv
// Receive-side write bus from the UART deserializer into the receive FIFO.
interface uart_rx_deserializer_if;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  modport master (output dout, output rx_done_tick, output frame_err);
  modport slave  (input  dout, input  rx_done_tick, input  frame_err);
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampled UART receiver: 7/8 data bits, 1/1.5/2 stop bits, one-cycle write strobe per byte.
// Define UART_RX_FRAME_ERR_EN to build the stop-bit framing error flag.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_tick,
  input  logic                          rx,
  input  logic                          data_bits_7,
  input  logic [1:0]                    stop_bits,
  uart_rx_deserializer_if.master        rx_if
);

  localparam int unsigned CntW = $clog2(2 * OVERSAMPLE) + 1;

  localparam logic [CntW-1:0] MidCnt    = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullCnt   = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] Stop1Tks  = CntW'(OVERSAMPLE);
  localparam logic [CntW-1:0] Stop15Tks = CntW'(OVERSAMPLE + OVERSAMPLE / 2);
  localparam logic [CntW-1:0] Stop2Tks  = CntW'(2 * OVERSAMPLE);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [1:0]      sync_q;
  logic            rx_s;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]      n_cnt_q, n_cnt_d;
  logic [7:0]      b_q, b_d;
  logic            nbits7_q, nbits7_d;
  logic [CntW-1:0] stop_ticks_q, stop_ticks_d;
  logic [7:0]      dout_q, dout_d;
  logic            done_q, done_d;
  logic [CntW-1:0] stop_ticks_sel;
  logic [2:0]      last_bit;

`ifdef UART_RX_FRAME_ERR_EN
  logic            ferr_q, ferr_d;
`endif

  assign rx_s     = sync_q[1];
  assign last_bit = nbits7_q ? 3'd6 : 3'd7;

  always_comb begin
    case (stop_bits)
      2'b00:   stop_ticks_sel = Stop1Tks;
      2'b01:   stop_ticks_sel = Stop15Tks;
      default: stop_ticks_sel = Stop2Tks;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    n_cnt_d      = n_cnt_q;
    b_d          = b_q;
    nbits7_d     = nbits7_q;
    stop_ticks_d = stop_ticks_q;
    dout_d       = dout_q;
    done_d       = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d       = ferr_q;
`endif

    case (state_q)
      // Start detection runs every clk; frame format is frozen here for the whole frame.
      StIdle: begin
        if (!rx_s) begin
          state_d      = StStart;
          s_cnt_d      = '0;
          nbits7_d     = data_bits_7;
          stop_ticks_d = stop_ticks_sel;
`ifdef UART_RX_FRAME_ERR_EN
          ferr_d       = 1'b0;
`endif
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_cnt_q == MidCnt) begin
            if (!rx_s) begin
              state_d = StData;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_cnt_d = s_cnt_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_cnt_q == FullCnt) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[7:1]};
            if (n_cnt_q == last_bit) begin
              state_d = StStop;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick) begin
`ifdef UART_RX_FRAME_ERR_EN
          if (s_cnt_q == FullCnt) begin
            ferr_d = ~rx_s;
          end
`endif
          if (s_cnt_q == stop_ticks_q - CntW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
            // 7-bit frames leave the first data bit in b_q[1]
            dout_d  = nbits7_q ? {1'b0, b_q[7:1]} : b_q;
          end else begin
            s_cnt_d = s_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b11;
      state_q      <= StIdle;
      s_cnt_q      <= '0;
      n_cnt_q      <= '0;
      b_q          <= '0;
      nbits7_q     <= 1'b0;
      stop_ticks_q <= Stop1Tks;
      dout_q       <= '0;
      done_q       <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q       <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], rx};
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      n_cnt_q      <= n_cnt_d;
      b_q          <= b_d;
      nbits7_q     <= nbits7_d;
      stop_ticks_q <= stop_ticks_d;
      dout_q       <= dout_d;
      done_q       <= done_d;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q       <= ferr_d;
`endif
    end
  end

  assign rx_if.dout         = dout_q;
  assign rx_if.rx_done_tick = done_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign rx_if.frame_err    = ferr_q & done_q;
`else
  assign rx_if.frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame-level model predicts every write strobe, byte and flag.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_bits_7 = 1'b0;
  logic [1:0] stop_bits = 2'b00;
  logic       s_tick;
  int unsigned cyc = 0;

`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FerrEn = 1'b1;
`else
  localparam bit FerrEn = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Edge number c (value of cyc before the edge) carries a tick when c % 4 == 3.
  assign s_tick = (cyc % 4 == 3);

  uart_rx_deserializer_if bus ();

  uart_rx_deserializer #(.OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .data_bits_7 (data_bits_7),
    .stop_bits   (stop_bits),
    .rx_if       (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
    logic        ferr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  logic [7:0]  exp_dout = 8'h00;
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  int          done_cnt = 0;
  logic        last_ferr = 1'b0;
  bit          due;

  // Ticks from START entry to the tick that ends the stop count.
  function automatic int unsigned frame_ticks(input bit n7, input logic [1:0] sb);
    int unsigned nb;
    int unsigned st;
    nb = n7 ? 7 : 8;
    st = (sb == 2'b00) ? 16 : (sb == 2'b01) ? 24 : 32;
    return 8 + 16 * nb + st;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (bus.rx_done_tick === 1'b1) begin
        done_cnt++;
        last_ferr = bus.frame_err;
      end
      if (due) begin
        ce = exp_q.pop_front();
        exp_dout = ce.data;
        if (bus.rx_done_tick !== 1'b1 || bus.dout !== ce.data || bus.frame_err !== ce.ferr) begin
          fails++;
          $display("FAIL frame @%0d: done=%b dout=%h ferr=%b, expected done=1 dout=%h ferr=%b",
                   cyc, bus.rx_done_tick, bus.dout, bus.frame_err, ce.data, ce.ferr);
        end
      end else if (bus.rx_done_tick !== 1'b0 || bus.frame_err !== 1'b0 || bus.dout !== exp_dout) begin
        fails++;
        $display("FAIL idle @%0d: done=%b dout=%h ferr=%b, expected done=0 dout=%h ferr=0",
                 cyc, bus.rx_done_tick, bus.dout, bus.frame_err, exp_dout);
      end
    end
  end

  task automatic send_frame(input logic [7:0] data, input bit n7, input logic [1:0] sb,
                            input bit stop_low);
    int unsigned c0;
    int unsigned t1;
    int          st_clk;
    exp_t        e;
    @(posedge clk);
    #1;
    data_bits_7 = n7;
    stop_bits   = sb;
    c0 = cyc - 1;
    // rx_s low after edge c0+2, START entered at edge c0+3; that edge's tick is not counted.
    t1 = c0 + 4;
    while (t1 % 4 != 3) t1++;
    e.cyc  = t1 + 4 * (frame_ticks(n7, sb) - 1) + 1;
    e.data = n7 ? {1'b0, data[6:0]} : data;
    e.ferr = FerrEn && stop_low;
    exp_q.push_back(e);
    rx = 1'b0;
    hold(64);
    for (int i = 0; i < (n7 ? 7 : 8); i++) begin
      rx = data[i];
      hold(64);
    end
    st_clk = (sb == 2'b00) ? 64 : (sb == 2'b01) ? 96 : 128;
    if (stop_low) begin
      rx = 1'b0;
      hold(64);
      rx = 1'b1;
      hold(st_clk - 64);
    end else begin
      rx = 1'b1;
      hold(st_clk);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx    = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_dout = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] b8n2 [3];
    logic [7:0] b7n15 [3];
    logic [7:0] b2b [4];
    int         base;
    logic [7:0] rb;
    logic [1:0] rsb;
    bit         rn7;
    bit         rlow;
    int         gap;

    b8n2  = '{8'h32, 8'h57, 8'hA5};
    b7n15 = '{8'h41, 8'h67, 8'h3A};
    b2b   = '{8'h79, 8'h12, 8'h6B, 8'h01};

    hold(3);
    check("reset_dout", bus.dout, 8'h00);
    check("reset_done", bus.rx_done_tick, 1'b0);
    check("reset_ferr", bus.frame_err, 1'b0);
    chk_en = 1'b1;
    reset  = 1'b0;
    hold(10);

    check("ticks_8n2", frame_ticks(1'b0, 2'b10), 168);
    check("ticks_7n15", frame_ticks(1'b1, 2'b01), 144);

    foreach (b8n2[i]) begin
      base = done_cnt;
      send_frame(b8n2[i], 1'b0, 2'b10, 1'b0);
      check("8n2_dout", bus.dout, b8n2[i]);
      check("8n2_count", done_cnt - base, 1);
      check("8n2_ferr", last_ferr, 1'b0);
    end

    foreach (b7n15[i]) begin
      send_frame(b7n15[i], 1'b1, 2'b01, 1'b0);
      check("7n15_dout", bus.dout, b7n15[i]);
    end
    send_frame(8'hC1, 1'b1, 2'b00, 1'b0);
    check("7bit_msb_clear", bus.dout, 8'h41);

    base = done_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(20);
    rx = 1'b1;
    hold(44);
    check("glitch_no_done", done_cnt - base, 0);
    send_frame(8'h5A, 1'b0, 2'b00, 1'b0);
    check("after_glitch", bus.dout, 8'h5A);

    base = done_cnt;
    foreach (b2b[i]) send_frame(b2b[i], 1'b1, 2'b00, 1'b0);
    check("b2b_count", done_cnt - base, 4);
    check("b2b_last", bus.dout, 8'h01);

    send_frame(8'hAC, 1'b0, 2'b10, 1'b1);
    check("ferr_dout", bus.dout, 8'hAC);
    check("ferr_flag", last_ferr, FerrEn);

    base = done_cnt;
    @(posedge clk);
    #1;
    data_bits_7 = 1'b0;
    stop_bits   = 2'b00;
    rx = 1'b0;
    hold(64);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h55 >> i) & 8'h01;
      hold(64);
    end
    rx = 1'b0;
    hold(30);
    do_reset();
    hold(100);
    check("abort_no_done", done_cnt - base, 0);
    check("abort_dout", bus.dout, 8'h00);
    send_frame(8'h91, 1'b0, 2'b00, 1'b0);
    check("after_abort", bus.dout, 8'h91);

    fork
      send_frame(8'hC3, 1'b0, 2'b00, 1'b0);
      begin
        hold(300);
        stop_bits = 2'b10;
        hold(200);
        stop_bits = 2'b01;
      end
    join
    check("toggle_dout", bus.dout, 8'hC3);

    for (int n = 0; n < 30; n++) begin
      rb   = 8'($urandom);
      rn7  = 1'($urandom_range(0, 1));
      rsb  = 2'($urandom_range(0, 3));
      rlow = rsb[1] && ($urandom_range(0, 3) == 0);
      send_frame(rb, rn7, rsb, rlow);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
        rx = 1'b0;
        hold(20);
        rx = 1'b1;
        hold(44);
      end
      gap = int'($urandom_range(0, 80));
      if (gap > 0) hold(gap);
    end

    hold(100);
    check("all_frames_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Oversampled serial receiver stage of the UART core. Sits between the `rx` pin and the receive FIFO. Consumes the 16x baud tick from the baud-rate generator and deserializes 7- or 8-bit frames with 1, 1.5 or 2 stop bits. Each completed byte is presented to the FIFO with a one-cycle write strobe.

## Interface
- `OVERSAMPLE`, 16: ticks per bit. Must be a power of two, at least 8.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `s_tick`  in  1  oversample tick from the baud generator. One-`clk` pulse, 16 per bit period.
- `rx`  in  1  asynchronous serial input. Idles high.
- `data_bits_7`  in  1  1 = 7 data bits, 0 = 8 data bits (control register bit 15).
- `stop_bits`  in  2  00 = 1, 01 = 1.5, 10 = 2 stop bits; 11 is treated as 2 (control register bits 14:13).
- `dout`  out  8  received byte, LSB-first reassembled. In 7-bit mode, bit 7 = 0.
- `rx_done_tick`  out  1  one-`clk` pulse when `dout` is valid. Drives the FIFO write enable.
- `frame_err`  out  1  one-`clk` pulse coincident with `rx_done_tick` when the stop bit sampled low. Only active with the configuration macro.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value `rx_s`.
- Internal registers:
  - `state`
  - `s_cnt[5:0]`: tick counter
  - `n_cnt[2:0]`: bit counter
  - `b_reg[7:0]`: shift register
  - latched `nbits_l`, `stop_ticks_l`
  - `ferr_l`
- The FSM advances only on `clk` edges where `s_tick`=1, except for the IDLE exit.
- IDLE:
  - On `rx_s`=0 (checked every `clk`, independent of `s_tick`): go to START, clear `s_cnt`.
  - Latch `nbits_l` = 7 or 8.
  - Latch `stop_ticks_l` = 16 / 24 / 32 for 1 / 1.5 / 2 stop bits.
  - Clear `ferr_l`.
- START, on `s_tick`:
  - If `s_cnt`==7 (start-bit midpoint): if `rx_s`==0, go to DATA with `s_cnt`=0, `n_cnt`=0. Otherwise return to IDLE (glitch reject, no output).
  - Else increment `s_cnt`.
- DATA, on `s_tick`:
  - If `s_cnt`==15: set `s_cnt`=0 and `b_reg` = {`rx_s`, `b_reg[7:1]`}. If `n_cnt`==`nbits_l`-1, go to STOP; else increment `n_cnt`.
  - Else increment `s_cnt`.
- STOP, on `s_tick`:
  - When `s_cnt`==15, sample `rx_s` into `ferr_l` (inverted).
  - If `s_cnt`==`stop_ticks_l`-1: go to IDLE and pulse `rx_done_tick`.
  - Else increment `s_cnt`.
- Output mapping: `dout` = `b_reg` in 8-bit mode, {1'b0, `b_reg[7:1]`} in 7-bit mode.
- `dout` holds its value until the next completed frame.
- Changes to `data_bits_7` or `stop_bits` mid-frame do not affect the current frame. They take effect at the next IDLE→START transition.
- The block has no backpressure. FIFO overflow handling belongs to the FIFO.

## Timing
- Reset values:
  - `state`=IDLE
  - `dout`=8'h00, `rx_done_tick`=0, `frame_err`=0
  - `b_reg`=0, counters=0
  - synchronizer flops=1
- Reset asserted mid-frame aborts the frame within one `clk`. No `rx_done_tick` is issued for the aborted frame.
- Falling edge on `rx` to START entry: 2 `clk` of synchronizer latency plus 1 `clk`.
- Each data bit is sampled at its midpoint: 8 + 16·k ticks after the start edge, k = 1..`nbits_l`.
- `rx_done_tick` is asserted `clk` cycles after the `s_tick` that completes the STOP count, for exactly 1 `clk`. `dout` is valid in the same cycle.
- `s_tick` arriving in the same `clk` as the IDLE→START transition is not counted.
- Back-to-back frames: a new start edge is accepted the `clk` after returning to IDLE. There is no dead time beyond the stop count.
- `s_cnt` is 6 bits, enough for counts up to 31. It never wraps because each state compares against its own terminal value.

## Configuration
- `UART_RX_FRAME_ERR_EN` defined:
  - `ferr_l` is captured at the first stop-bit midpoint.
  - `frame_err` = `ferr_l` & `rx_done_tick`.
- Not defined:
  - `frame_err` is tied to 0 and `ferr_l` is not synthesized.
  - All other behaviour is identical.

## Test plan
- Bench setup: `s_tick` every 4 `clk`. Frames drive `rx` for 64 `clk` per bit.
- 8N, 2 stop bits, byte 0x32 → exactly one `rx_done_tick` with `dout`=0x32 and `frame_err`=0. Repeat with 0x57 and 0xA5.
- 7 data bits, 1.5 stop bits, byte 0x41 (then 0x67, 0x3A) → `dout`=0x41 with bit 7 = 0. `rx_done_tick` occurs 24 ticks after the last data-bit midpoint.
- 20-`clk` low glitch on idle `rx` → no `rx_done_tick`, and `state` returns to IDLE by tick 7.
- Four back-to-back 7-bit, 1-stop frames 0x79, 0x12, 0x6B, 0x01 → four pulses in order with matching `dout`.
- Stop bit forced low on byte 0xAC, with `UART_RX_FRAME_ERR_EN` defined → `dout`=0xAC and `frame_err`=1 coincident with `rx_done_tick`. With the macro undefined, `frame_err`=0.
- Reset asserted during data bit 3 of 0x55, then a clean 0x91 frame → no output for 0x55, then `dout`=0x91. Toggling `stop_bits` mid-frame leaves that frame's `rx_done_tick` timing unchanged.
